// File: rtl/dot3x3_sequencer.sv
// dot3x3_sequencer: streams 9 operand words into the 3x3 dot-product
// datapath, then walks dp_sel over all 9 positions and returns each result.
module dot3x3_sequencer #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] dp_in,
    output logic        dp_wr,
    output logic [3:0]  dp_mem_sel,
    output logic [3:0]  dp_sel,
    input  logic [31:0] dp_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_idx,
    output logic        res_last,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [3:0] LAST_WORD   = 4'd8;
    localparam logic [3:0] LAST_IDX    = 4'd8;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [1:0]  r_q, r_d;
    logic [1:0]  c_q, c_d;
    logic [3:0]  scnt_q, scnt_d;
    logic [31:0] dp_in_q, dp_in_d;
    logic        dp_wr_q, dp_wr_d;
    logic [3:0]  dp_mem_sel_q, dp_mem_sel_d;
    logic [31:0] res_data_q, res_data_d;
    logic [3:0]  res_idx_q, res_idx_d;
    logic        done_q, done_d;

    logic        in_accept;
    logic        res_accept;
    logic        sel_active;
    logic [3:0]  idx_cur;

    assign in_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign res_valid  = (state_q == S_RESULT);
    assign busy       = (state_q != S_IDLE);
    assign sel_active = (state_q == S_SETTLE) || (state_q == S_RESULT);
    assign dp_sel     = sel_active ? {c_q, r_q} : 4'd0;
    assign res_last   = res_valid && (res_idx_q == LAST_IDX);

    assign dp_in      = dp_in_q;
    assign dp_wr      = dp_wr_q;
    assign dp_mem_sel = dp_mem_sel_q;
    assign res_data   = res_data_q;
    assign res_idx    = res_idx_q;
    assign done       = done_q;

    assign in_accept  = in_valid && in_ready;
    assign res_accept = res_valid && res_ready;

    // 3*r + c without a multiplier
    assign idx_cur = {1'b0, r_q, 1'b0} + {2'b00, r_q} + {2'b00, c_q};

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        r_d          = r_q;
        c_d          = c_q;
        scnt_d       = scnt_q;
        dp_in_d      = dp_in_q;
        dp_wr_d      = 1'b0;
        dp_mem_sel_d = dp_mem_sel_q;
        res_data_d   = res_data_q;
        res_idx_d    = res_idx_q;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_accept) begin
                    dp_in_d      = in_data;
                    dp_mem_sel_d = wcnt_q;
                    dp_wr_d      = 1'b1;
                    wcnt_d       = wcnt_q + 4'd1;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_accept) begin
                    dp_in_d      = in_data;
                    dp_mem_sel_d = wcnt_q;
                    dp_wr_d      = 1'b1;
                    wcnt_d       = wcnt_q + 4'd1;
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_d  = 4'd0;
                        r_d     = 2'd0;
                        c_d     = 2'd0;
                        scnt_d  = 4'd0;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (scnt_q == SETTLE_LAST) begin
                    res_data_d = dp_out;
                    res_idx_d  = idx_cur;
                    scnt_d     = 4'd0;
                    state_d    = S_RESULT;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end
            S_RESULT: begin
                if (res_accept) begin
                    if (res_idx_q == LAST_IDX) begin
                        r_d     = 2'd0;
                        c_d     = 2'd0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        if (c_q == 2'd2) begin
                            c_d = 2'd0;
                            r_d = r_q + 2'd1;
                        end else begin
                            c_d = c_q + 2'd1;
                        end
                        scnt_d  = 4'd0;
                        state_d = S_SETTLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides any handshake taken this cycle
        if (abort) begin
            state_d      = S_IDLE;
            wcnt_d       = 4'd0;
            r_d          = 2'd0;
            c_d          = 2'd0;
            scnt_d       = 4'd0;
            dp_in_d      = dp_in_q;
            dp_wr_d      = 1'b0;
            dp_mem_sel_d = dp_mem_sel_q;
            res_data_d   = res_data_q;
            res_idx_d    = res_idx_q;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wcnt_q       <= 4'd0;
            r_q          <= 2'd0;
            c_q          <= 2'd0;
            scnt_q       <= 4'd0;
            dp_in_q      <= 32'd0;
            dp_wr_q      <= 1'b0;
            dp_mem_sel_q <= 4'd0;
            res_data_q   <= 32'd0;
            res_idx_q    <= 4'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            r_q          <= r_d;
            c_q          <= c_d;
            scnt_q       <= scnt_d;
            dp_in_q      <= dp_in_d;
            dp_wr_q      <= dp_wr_d;
            dp_mem_sel_q <= dp_mem_sel_d;
            res_data_q   <= res_data_d;
            res_idx_q    <= res_idx_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_dot3x3_sequencer.sv
// tb_dot3x3_sequencer: randomized bench with an operand-register datapath
// stand-in and a transaction-level reference for dot3x3_sequencer.
module tb_dot3x3_sequencer;

    localparam int unsigned SETTLE_CYC = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic [31:0] dp_in;
    logic        dp_wr;
    logic [3:0]  dp_mem_sel;
    logic [3:0]  dp_sel;
    logic [31:0] dp_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [3:0]  res_idx;
    logic        res_last;
    logic        busy;
    logic        done;

    dot3x3_sequencer #(.SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .reset(reset), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_in(dp_in), .dp_wr(dp_wr), .dp_mem_sel(dp_mem_sel),
        .dp_sel(dp_sel), .dp_out(dp_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .res_last(res_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // datapath stand-in: operand registers plus combinational dot product
    logic [15:0] dpa [9];
    logic [15:0] dpb [9];

    always @(posedge clk) begin
        if (dp_wr && dp_mem_sel < 4'd9) begin
            dpa[dp_mem_sel] <= dp_in[31:16];
            dpb[dp_mem_sel] <= dp_in[15:0];
        end
    end

    always_comb begin
        dp_out = 32'd0;
        if (dp_sel[1:0] != 2'b11 && dp_sel[3:2] != 2'b11)
            for (int k = 0; k < 3; k++)
                dp_out = dp_out
                    + 32'(dpa[int'(dp_sel[1:0]) * 3 + k])
                    * 32'(dpb[k * 3 + int'(dp_sel[3:2])]);
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] matc(input logic [31:0] w [9],
                                         input int idx);
        logic [31:0] s;
        int r;
        int c;
        s = 32'd0;
        r = idx / 3;
        c = idx % 3;
        for (int k = 0; k < 3; k++)
            s = s + 32'(w[r * 3 + k][31:16]) * 32'(w[k * 3 + c][15:0]);
        return s;
    endfunction

    // reference: words loaded so far, then a walk over result indices
    bit          m_init = 0;
    int          m_loaded = 0;
    bit          m_comp = 0;
    bit          m_resv = 0;
    int          m_k = 0;
    int          m_wait = 0;
    logic [31:0] m_w [9];
    logic [31:0] m_c [9];
    bit          e_wr = 0;
    bit          e_done = 0;
    int          e_addr = 0;
    logic [31:0] e_din = 32'd0;

    logic [31:0] log_data [$];
    int          log_idx [$];
    bit          log_last [$];
    int          wr_addr [$];
    int          done_cnt = 0;
    int          acc_cyc = 0;
    int          rv_cyc = 0;
    bit          seen_rv = 0;

    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            if (m_init) begin
                chk("in_ready", 32'(in_ready), 32'(!m_comp));
                chk("busy", 32'(busy), 32'(m_comp || m_loaded != 0));
                chk("res_valid", 32'(res_valid), 32'(m_resv));
                chk("res_last", 32'(res_last), 32'(m_resv && m_k == 8));
                chk("dp_wr", 32'(dp_wr), 32'(e_wr));
                chk("done", 32'(done), 32'(e_done));
                chk("dp_sel", 32'(dp_sel),
                    m_comp ? 32'((m_k % 3) * 4 + m_k / 3) : 32'd0);
                if (e_wr) begin
                    chk("dp_mem_sel", 32'(dp_mem_sel), 32'(e_addr));
                    chk("dp_in", dp_in, e_din);
                end
                if (m_resv) begin
                    chk("res_idx", 32'(res_idx), 32'(m_k));
                    chk("res_data", res_data, m_c[m_k]);
                end
            end
            if (dp_wr) wr_addr.push_back(int'(dp_mem_sel));
            if (m_init && !reset && !abort) begin
                if (in_valid && in_ready) begin
                    acc_cyc = cyc;
                    seen_rv = 0;
                end
                if (res_valid && !seen_rv) begin
                    rv_cyc = cyc;
                    seen_rv = 1;
                end
                if (res_valid && res_ready) begin
                    log_data.push_back(res_data);
                    log_idx.push_back(int'(res_idx));
                    log_last.push_back(res_last);
                end
            end
            if (done) done_cnt++;
            e_wr = 0;
            e_done = 0;
            if (reset) begin
                m_init = 1;
                m_loaded = 0;
                m_comp = 0;
                m_resv = 0;
                m_k = 0;
            end else if (!m_init) begin
                m_loaded = 0;
            end else if (abort) begin
                m_loaded = 0;
                m_comp = 0;
                m_resv = 0;
                m_k = 0;
            end else if (!m_comp) begin
                if (in_valid) begin
                    e_wr = 1;
                    e_addr = m_loaded;
                    e_din = in_data;
                    m_w[m_loaded] = in_data;
                    m_loaded++;
                    if (m_loaded == 9) begin
                        m_comp = 1;
                        m_k = 0;
                        m_wait = SETTLE_CYC;
                        for (int i = 0; i < 9; i++) m_c[i] = matc(m_w, i);
                    end
                end
            end else if (m_resv) begin
                if (res_ready) begin
                    m_resv = 0;
                    if (m_k == 8) begin
                        m_comp = 0;
                        m_loaded = 0;
                        e_done = 1;
                    end else begin
                        m_k++;
                        m_wait = SETTLE_CYC;
                    end
                end
            end else begin
                m_wait--;
                if (m_wait == 0) m_resv = 1;
            end
        end
    end

    // res_ready policy: 0 = always, 1 = random, 2 = driven by the test
    int rr_mode = 2;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 0) res_ready = 1'b1;
            else if (rr_mode == 1) res_ready = 1'($urandom_range(1, 0));
        end
    end

    logic [31:0] op_w [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        bit ok;
        ok = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data = $urandom;
            step();
        end
        in_valid = 1'b1;
        in_data = w;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            step();
        end
        if (ok) step();
        chk("in_accept", 32'(ok), 32'd1);
    endtask

    task automatic load(input int n, input int mode, input bit keep);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = 0;
            if (mode == 1) gap = (i > 0) ? 1 : 0;
            if (mode == 2) gap = int'($urandom_range(3, 0));
            send_word(op_w[i], gap);
        end
        in_valid = keep;
        in_data = $urandom;
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_res(input int idx, input int budget);
        bit got;
        got = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (res_valid && int'(res_idx) == idx) begin
                got = 1;
                break;
            end
        end
        chk("res_seen", 32'(got), 32'd1);
    endtask

    task automatic set_op(input int kind);
        logic [15:0] a;
        logic [15:0] b;
        for (int k = 0; k < 9; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (kind == 0 || kind == 2) a = (k % 4 == 0) ? 16'd1 : 16'd0;
            if (kind == 0) b = 16'(k + 1);
            if (kind == 1) begin
                a = 16'd2;
                b = 16'd3;
            end
            if (kind == 2) b = 16'hFFFF;
            op_w[k] = {a, b};
        end
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_idx.delete();
        log_last.delete();
        wr_addr.delete();
    endtask

    int base_done;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_dp_wr", 32'(dp_wr), 32'd0);
        chk("rst_dp_sel", 32'(dp_sel), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_idx", 32'(res_idx), 32'd0);
        chk("rst_dp_in", dp_in, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        step();

        // identity times 1..9
        rr_mode = 0;
        clear_logs();
        set_op(0);
        load(9, 0, 0);
        wait_done(200);
        chk("t1_busy_after", 32'(busy), 32'd0);
        step();
        chk("t1_count", 32'(log_data.size()), 32'd9);
        for (int i = 0; i < log_data.size(); i++) begin
            chk("t1_data", log_data[i], 32'(i + 1));
            chk("t1_idx", 32'(log_idx[i]), 32'(i));
            chk("t1_last", 32'(log_last[i]), 32'(i == 8));
        end

        // constant 2 x constant 3, first-result latency
        clear_logs();
        set_op(1);
        load(9, 0, 0);
        wait_done(200);
        step();
        chk("t2_latency", 32'(rv_cyc - acc_cyc), 32'(SETTLE_CYC + 1));
        chk("t2_count", 32'(log_data.size()), 32'd9);
        for (int i = 0; i < log_data.size(); i++)
            chk("t2_data", log_data[i], 32'd18);

        // backpressure held at idx 4
        rr_mode = 2;
        res_ready = 1'b1;
        set_op(3);
        load(9, 0, 0);
        wait_res(3, 200);
        step();
        res_ready = 1'b0;
        wait_res(4, 200);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                step();
                @(negedge clk);
            end
            chk("t3_valid", 32'(res_valid), 32'd1);
            chk("t3_idx", 32'(res_idx), 32'd4);
            chk("t3_sel", 32'(dp_sel), 32'h5);
            chk("t3_data", res_data, matc(op_w, 4));
        end
        step();
        res_ready = 1'b1;
        wait_res(5, 50);
        step();
        rr_mode = 0;
        wait_done(200);
        step();

        // toggling load, in_valid high through compute
        clear_logs();
        set_op(3);
        load(9, 1, 1);
        wait_res(8, 200);
        step();
        in_valid = 1'b0;
        wait_done(50);
        step();
        chk("t4_wr_count", 32'(wr_addr.size()), 32'd9);
        for (int i = 0; i < wr_addr.size(); i++)
            chk("t4_wr_addr", 32'(wr_addr[i]), 32'(i));

        // reset mid-load, then fresh identity x 0xFFFF
        set_op(3);
        load(4, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_logs();
        set_op(2);
        load(9, 0, 0);
        wait_done(200);
        step();
        chk("t5_wr_count", 32'(wr_addr.size()), 32'd9);
        if (wr_addr.size() > 0) chk("t5_first_addr", 32'(wr_addr[0]), 32'd0);
        chk("t5_count", 32'(log_data.size()), 32'd9);
        for (int i = 0; i < log_data.size(); i++)
            chk("t5_data", log_data[i], 32'h0000FFFF);

        // abort at idx 2 together with res_ready
        set_op(3);
        rr_mode = 0;
        load(9, 0, 0);
        wait_res(1, 200);
        repeat (SETTLE_CYC + 1) step();
        abort = 1'b1;
        base_done = done_cnt;
        @(negedge clk);
        chk("t6_valid", 32'(res_valid), 32'd1);
        chk("t6_idx", 32'(res_idx), 32'd2);
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        repeat (4) step();
        chk("t6_no_done", 32'(done_cnt), 32'(base_done));
        clear_logs();
        set_op(3);
        rr_mode = 1;
        load(9, 2, 0);
        wait_done(500);
        step();
        chk("t6_count", 32'(log_data.size()), 32'd9);
        for (int i = 0; i < log_data.size(); i++)
            chk("t6_data", log_data[i], matc(op_w, i));

        // random operations with gaps and backpressure
        repeat (6) begin
            set_op(3);
            rr_mode = 1;
            load(9, 2, 0);
            wait_done(500);
            step();
        end

        // random aborts during compute
        repeat (3) begin
            set_op(3);
            rr_mode = 1;
            load(9, 2, 0);
            repeat ($urandom_range(30, 0)) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
            @(negedge clk);
            chk("abort_busy", 32'(busy), 32'd0);
            step();
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
